// File: rtl/lut_serial_loader.sv
// Serialises NUM_WORDS table words MSB-first onto the LUT d/cs_n load pins.
// Optional feature macro: LUT_LOADER_PARITY_EN adds a frame_parity output.
module lut_serial_loader #(
    parameter int WORD_WIDTH = 8,
    parameter int NUM_WORDS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  sd,
    output logic                  scs_n,
    output logic                  busy,
`ifdef LUT_LOADER_PARITY_EN
    output logic                  frame_parity,
`endif
    output logic                  done
);

    localparam int BIT_CW  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int WORD_CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(WORD_WIDTH - 1);
    localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t               state;
    logic [WORD_WIDTH-1:0] shreg;
    logic [BIT_CW-1:0]     bit_cnt;
    logic [WORD_CW-1:0]    word_cnt;

    // Handshake: a word transfers on the rising edge where in_valid && in_ready;
    // in_ready is registered and is only high while waiting for the next word.
    // On acceptance the MSB goes straight to sd, so shreg only holds the remaining bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            in_ready <= 1'b0;
            sd       <= 1'b0;
            scs_n    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef LUT_LOADER_PARITY_EN
            frame_parity <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_WAIT;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        word_cnt <= '0;
`ifdef LUT_LOADER_PARITY_EN
                        frame_parity <= 1'b0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (in_valid && in_ready) begin
                        state    <= ST_SHIFT;
                        sd       <= in_data[WORD_WIDTH-1];
                        shreg    <= in_data << 1;
                        bit_cnt  <= '0;
                        scs_n    <= 1'b0;
                        in_ready <= 1'b0;
`ifdef LUT_LOADER_PARITY_EN
                        // Every accepted bit is shifted out, so the word XOR is the shifted-bit XOR.
                        frame_parity <= frame_parity ^ (^in_data);
`endif
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        scs_n <= 1'b1;
                        sd    <= 1'b0;
                        if (word_cnt == LAST_WORD) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_WAIT;
                            word_cnt <= word_cnt + 1'b1;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        sd      <= shreg[WORD_WIDTH-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
